// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and default timing constants for the run-control sequencer
// Purpose: sequencer state encoding and board-rate defaults used by game_sequencer
//          and button_debouncer.
// Ports:   none (package).
package game_pkg;

  // Board defaults at 12 MHz: ~0.7 s per generation, ~5.5 ms debounce, 0.5 s long press.
  localparam int DEF_STEP_PERIOD     = 8388608;
  localparam int DEF_DEBOUNCE_CYCLES = 65536;
  localparam int DEF_LONG_PRESS      = 6000000;

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_PAUSED  = 3'd1,
    S_RUNNING = 3'd2,
    S_STEP    = 3'd3,
    S_HALTED  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/game_sequencer_button_debouncer.sv
// rtl/game_sequencer_button_debouncer.sv - 2-FF synchroniser plus stable-count debounce filter
// Purpose: clean up one raw push button and emit single-cycle press/release pulses.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   btn_i        raw asynchronous button level
//   level_o      debounced level
//   press_o      one-cycle pulse in the first cycle level_o is high
//   release_o    one-cycle pulse in the first cycle level_o is low
module button_debouncer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive synchronised samples that disagree with the
  // debounced level; any agreeing sample restarts the run.
  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d   = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - run-control sequencer for the Conway-cell grid
// Purpose: turns the two board buttons into load/run/pause/step, drives the
//          cell-array step enable and load pulse, counts generations and halts
//          on extinction or still life.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   buttons      raw buttons: [0] load, [1] run/step (short = pause/step, long = run)
//   cells_q      current cell states, N*N bits
//   cells_d      next-generation cell states, N*N bits
//   step_game    one-cycle cell enable
//   rst_game     cell load pulse (high in LOAD and during reset)
//   generation   generations stepped since last load (saturating)
//   running      high in RUNNING
//   halted       high in HALTED
module game_sequencer
  import game_pkg::*;
#(
  parameter int N               = 5,
  parameter int STEP_PERIOD     = DEF_STEP_PERIOD,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS      = DEF_LONG_PRESS,
  parameter int GEN_W           = 16,
  parameter int AUTO_RUN        = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       buttons,
  input  logic [N*N-1:0]   cells_q,
  input  logic [N*N-1:0]   cells_d,
  output logic             step_game,
  output logic             rst_game,
  output logic [GEN_W-1:0] generation,
  output logic             running,
  output logic             halted
);

  localparam int PW = $clog2(STEP_PERIOD);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(STEP_PERIOD - 1);
  // step_game is registered, so it is launched one count early.
  localparam logic [PW-1:0] PERIOD_PRE  = PW'(STEP_PERIOD - 2);

  localparam int LW = $clog2(LONG_PRESS + 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_PRESS);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_PRESS - 1);

  logic level0, press0, release0;
  logic level1, press1, release1;
  logic unused_evts;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_i     (buttons[0]),
    .level_o   (level0),
    .press_o   (press0),
    .release_o (release0)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_i     (buttons[1]),
    .level_o   (level1),
    .press_o   (press1),
    .release_o (release1)
  );

  assign unused_evts = &{level0, release0, press1};

  seq_state_t       state_q, state_d;
  logic [PW-1:0]    period_q, period_d;
  logic [LW-1:0]    press_cnt_q, press_cnt_d;
  logic [GEN_W-1:0] generation_q, generation_d;
  logic             step_game_q, step_game_d;
  logic             rst_game_q;
  logic             running_q, halted_q;

  logic long_evt, short_evt, halt_cond;

  // Held-cycle counter: the increment that lands on LONG_MAX is the long
  // event; saturation guarantees it fires once and marks the press as long.
  always_comb begin
    press_cnt_d = '0;
    if (level1) begin
      press_cnt_d = (press_cnt_q == LONG_MAX) ? press_cnt_q : press_cnt_q + 1'b1;
    end
  end

  assign long_evt  = level1 && (press_cnt_q == LONG_PRE);
  assign short_evt = release1 && (press_cnt_q != LONG_MAX);

  // Extinct or still life: stepping again would change nothing.
  assign halt_cond = (cells_q == '0) || (cells_d == cells_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:    state_d = (AUTO_RUN != 0) ? S_RUNNING : S_PAUSED;
      S_PAUSED: begin
        if (short_evt)     state_d = S_STEP;
        else if (long_evt) state_d = S_RUNNING;
      end
      S_RUNNING: if (short_evt) state_d = S_PAUSED;
      S_STEP:    state_d = S_PAUSED;
      S_HALTED:  if (long_evt)  state_d = S_RUNNING;
      default:   state_d = S_LOAD;
    endcase
    // step_game_q is only ever high in RUNNING or STEP.
    if (step_game_q && halt_cond) state_d = S_HALTED;
    if (press0)                   state_d = S_LOAD;
  end

  // The period counter only advances while staying in RUNNING, so it is
  // held at zero everywhere else and every entry to RUNNING starts afresh.
  always_comb begin
    period_d = '0;
    if (state_q == S_RUNNING && state_d == S_RUNNING) begin
      period_d = (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;
    end
  end

  assign step_game_d = (state_d == S_STEP) ||
                       (state_q == S_RUNNING && state_d == S_RUNNING && period_q == PERIOD_PRE);

  always_comb begin
    generation_d = generation_q;
    if (step_game_q && generation_q != '1) generation_d = generation_q + 1'b1;
    if (state_q == S_LOAD || state_d == S_LOAD) generation_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      period_q     <= '0;
      press_cnt_q  <= '0;
      generation_q <= '0;
      step_game_q  <= 1'b0;
      rst_game_q   <= 1'b1;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      press_cnt_q  <= press_cnt_d;
      generation_q <= generation_d;
      step_game_q  <= step_game_d;
      rst_game_q   <= (state_d == S_LOAD);
      running_q    <= (state_d == S_RUNNING);
      halted_q     <= (state_d == S_HALTED);
    end
  end

  assign step_game  = step_game_q;
  assign rst_game   = rst_game_q;
  assign generation = generation_q;
  assign running    = running_q;
  assign halted     = halted_q;

endmodule
